float12_accum: RTL

// - Streaming accumulator for 12-bit floats (sign[11], exp[10:6] bias 15, mant[5:0], hidden 1); sits directly downstream of the 12-bit float multiplier.
// - Sums one group of products per neuron (valid_i/last_i framed) and presents each finished sum on a held result port with a valid/ready handshake.
// - Flags overrun when a group finishes while the previous sum is still unaccepted; the input side has no backpressure.

---
 rtl/float12_pkg.sv | 31 +++
 rtl/float12_add.sv | 84 ++++++++
 rtl/float12_accum.sv | 114 +++++++++++
 3 files changed

// File: rtl/float12_pkg.sv
// ============================================================
// float12_pkg : shared 12-bit float constants, types and helpers
// Rev 1.0
// ============================================================
`default_nettype none

package float12_pkg;

  localparam int SGN_BIT  = 11;
  localparam int EXP_MSB  = 10;
  localparam int EXP_LSB  = 6;
  localparam int MAN_W    = 6;
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX  = 31;

  localparam logic [11:0] F12_ZERO = 12'h000;
  localparam logic [10:0] MAG_SAT  = 11'h7FF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } acc_state_e;

  // A zero exponent field encodes zero regardless of mantissa
  function automatic logic f12_is_zero(input logic [11:0] x);
    return (x[EXP_MSB:EXP_LSB] == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/float12_add.sv
// ============================================================
// float12_add : combinational 12-bit float adder, 1 guard bit, round-half-up
// Rev 1.0
// ============================================================
`default_nettype none

module float12_add
  import float12_pkg::*;
(
  input  logic [11:0] a_i,
  input  logic [11:0] b_i,
  output logic [11:0] sum_o
);

  logic             swap;
  logic [11:0]      l_op, s_op;
  logic [4:0]       l_exp, s_exp, exp_diff;
  logic [MAN_W+1:0] l_sig, s_sig, s_al;
  logic [MAN_W+2:0] raw;
  logic [MAN_W+1:0] norm;
  logic [3:0]       lz;
  logic [6:0]       e;
  logic [7:0]       rnd;
  logic [MAN_W-1:0] mant;
  logic             res_sgn;
  logic             is_zero;

  always_comb begin
    swap     = (b_i[EXP_MSB:0] > a_i[EXP_MSB:0]);
    l_op     = swap ? b_i : a_i;
    s_op     = swap ? a_i : b_i;
    l_exp    = l_op[EXP_MSB:EXP_LSB];
    s_exp    = s_op[EXP_MSB:EXP_LSB];
    l_sig    = f12_is_zero(l_op) ? '0 : {1'b1, l_op[MAN_W-1:0], 1'b0};
    s_sig    = f12_is_zero(s_op) ? '0 : {1'b1, s_op[MAN_W-1:0], 1'b0};
    exp_diff = l_exp - s_exp;
    s_al     = (exp_diff >= 5'd8) ? '0 : (s_sig >> exp_diff);
    e        = {2'b00, l_exp};
    res_sgn  = l_op[SGN_BIT];
    lz       = 4'd8;
    norm     = '0;
    mant     = '0;
    rnd      = '0;

    if (a_i[SGN_BIT] == b_i[SGN_BIT]) begin
      raw = {1'b0, l_sig} + {1'b0, s_al};
      if (raw[MAN_W+2]) begin
        norm = raw[MAN_W+2:1];
        e    = e + 7'd1;
      end else begin
        norm = raw[MAN_W+1:0];
      end
    end else begin
      raw = {1'b0, l_sig} - {1'b0, s_al};
      for (int i = 0; i < MAN_W + 2; i++) begin
        if (raw[i]) lz = 4'(MAN_W + 1 - i);
      end
      norm = raw[MAN_W+1:0] << lz;
      e    = e - {3'b000, lz};
    end

    is_zero = (norm == '0) || e[6] || (e == 7'd0);

    if (is_zero) begin
      sum_o = F12_ZERO;
    end else if (e >= 7'(EXP_MAX)) begin
      sum_o = {res_sgn, MAG_SAT};
    end else begin
      // Guard bit rounds half-up; a full carry bumps the exponent
      rnd = {1'b0, norm[MAN_W+1:1]} + 8'(norm[0]);
      if (rnd[MAN_W+1]) begin
        e    = e + 7'd1;
        mant = rnd[MAN_W:1];
      end else begin
        mant = rnd[MAN_W-1:0];
      end
      if (e >= 7'(EXP_MAX)) sum_o = {res_sgn, MAG_SAT};
      else                  sum_o = {res_sgn, e[4:0], mant};
    end
  end

endmodule

`default_nettype wire

// File: rtl/float12_accum.sv
// ============================================================
// float12_accum : framed 12-bit float accumulator with held valid/ready result
// Rev 1.0
// ============================================================
`default_nettype none

module float12_accum
  import float12_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [11:0]      data_i,
  input  logic             valid_i,
  input  logic             last_i,
  output logic [11:0]      sum_o,
  output logic             sum_valid_o,
  input  logic             sum_ready_i,
  output logic [CNT_W-1:0] count_o,
  output logic             overrun_o
);

  acc_state_e       state_q, state_d;
  logic             s0_valid_q, s0_last_q;
  logic [11:0]      s0_data_q;
  logic [11:0]      acc_q, acc_d, add_res;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [11:0]      sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sum_valid_q, sum_valid_d;
  logic             overrun_q, overrun_d;
  logic             load;

  float12_add u_add (
    .a_i   (acc_q),
    .b_i   (s0_data_q),
    .sum_o (add_res)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_valid_q  <= 1'b0;
      s0_last_q   <= 1'b0;
      s0_data_q   <= F12_ZERO;
      state_q     <= ST_IDLE;
      acc_q       <= F12_ZERO;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      sum_q       <= F12_ZERO;
      count_q     <= '0;
      sum_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      s0_valid_q <= valid_i;
      if (valid_i) begin
        s0_data_q <= f12_is_zero(data_i) ? F12_ZERO : data_i;
        s0_last_q <= last_i;
      end
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      sum_valid_q <= sum_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    sum_d       = sum_q;
    count_d     = count_q;
    sum_valid_d = sum_valid_q;
    overrun_d   = overrun_q;

    // IDLE means the next beat opens a group and replaces the accumulator
    if (s0_valid_q) begin
      if (state_q == ST_IDLE) begin
        acc_d = s0_data_q;
        cnt_d = CNT_W'(1);
      end else begin
        acc_d = add_res;
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      end
      state_d = s0_last_q ? ST_IDLE : ST_ACC;
      done_d  = s0_last_q;
    end

    load = done_q && (!sum_valid_q || sum_ready_i);
    if (load) begin
      sum_d       = acc_q;
      count_d     = cnt_q;
      sum_valid_d = 1'b1;
    end else if (sum_ready_i) begin
      sum_valid_d = 1'b0;
    end

    if (done_q && sum_valid_q && !sum_ready_i) overrun_d = 1'b1;
  end

  assign sum_o       = sum_q;
  assign count_o     = count_q;
  assign sum_valid_o = sum_valid_q;
  assign overrun_o   = overrun_q;

endmodule

`default_nettype wire
